data_sram_axi_bridge: RTL and testbench
=======================================

Name: data_sram_axi_bridge

Overview:
- Downstream consumer of the memory stage's data-side SRAM-like interface (req/wr/size/addr/wdata/uncached in; rdata/addr_ok/data_ok out).
- Converts each request into a single-beat AXI4 read or write transaction, one transaction outstanding at a time.
- Sits between the memory stage and the data-side AXI port of the top-level interconnect.

Parameters:
- AXI_ID, 4'd1, constant ID driven on arid/awid.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- data_req  in  1  request valid from memory stage
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  physical byte address
- data_wdata  in  32  store data, lane-replicated by producer
- data_uncached  in  1  1 = uncached access
- data_rdata  out  32  load data, valid when data_data_ok is high
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  one-cycle completion pulse
- arid/awid  out  4  AXI_ID
- araddr/awaddr  out  32  latched address
- arlen/awlen  out  8  0
- arsize/awsize  out  3  {1'b0, size}
- arburst/awburst  out  2  2'b01
- arlock/awlock  out  2  0
- arcache/awcache  out  4  uncached ? 4'b0000 : 4'b1111
- arprot/awprot  out  3  0
- arvalid, arready  out, in  1  AR handshake
- rid in 4; rdata in 32; rresp in 2; rlast in 1
- rvalid, rready  in, out  1  R handshake
- awvalid, awready  out, in  1  AW handshake
- wid out 4 (AXI_ID); wdata out 32; wstrb out 4; wlast out 1 (const 1)
- wvalid, wready  out, in  1  W handshake
- bid in 4; bresp in 2
- bvalid, bready  in, out  1  B handshake

Behaviour:
- Reset: state IDLE; all latches zero; arvalid = awvalid = wvalid = rready = bready = data_addr_ok = data_data_ok = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR (AW/W pending), WR_RESP.
- IDLE:
  - data_addr_ok = data_req, combinational.
  - On data_req, latch addr, size, wdata, uncached and computed strobe.
  - Next state is RD_ADDR if !data_wr, else WR. An AW_done/W_done pair of flags is cleared on entry to WR.
- RD_ADDR: arvalid = 1. On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: data_data_ok = 1 and data_rdata = rdata, both combinational in the same cycle; next state IDLE.
- WR:
  - awvalid = !AW_done; wvalid = !W_done.
  - Each flag sets on its own handshake. AW and W may complete in either order or in the same cycle.
  - When both are done (counting handshakes in the current cycle), go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid: data_data_ok = 1 and data_rdata = 0; next state IDLE.
- data_addr_ok is 0 in every non-IDLE state. The earliest next acceptance is the cycle after data_data_ok.
- Minimum latency, load: addr_ok at cycle 0; arvalid at cycles 1+; data_ok in the cycle rvalid is seen, no earlier than cycle 2.
- Minimum latency, store: addr_ok at cycle 0; aw/w at cycle 1; data_ok no earlier than cycle 2.
- Valid stability: arvalid, awvalid and wvalid stay high with stable payload until their handshake. Payload is driven from the latches, never from live data_* inputs.
- Strobe, from addr[1:0]:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << addr[1:0]; addr[0] is guaranteed 0 upstream.
  - size 2: 4'b1111.
  - size 3: strobe 4'b0000 and still issue the transaction.
- wdata = latched data_wdata, unmodified.
- rresp/bresp errors, rid/bid and rlast are ignored; completion is signalled regardless.
- rvalid in a non-RD_DATA state, or bvalid in a non-WR_RESP state, is ignored (ready is low).
- rst asserted mid-transaction: return to IDLE next edge, drop all valids. No completion pulse is produced; the interconnect is reset together with the core.

Test Plan:
- Load word, addr 0x00001004, arready delayed 2 cycles, rdata 0xDEADBEEF one cycle after AR -> addr_ok at cycle 0; arvalid held cycles 1–3 with araddr 0x00001004, arsize 3'b010, arcache 4'b1111; data_ok pulse with data_rdata 0xDEADBEEF.
- Store byte, addr 0x1FC00003, wdata 0xABABABAB, uncached=1 -> awaddr 0x1FC00003, awsize 0, awcache 0, wstrb 4'b1000, wdata 0xABABABAB; data_ok only on bvalid.
- Store half at 0x102, wready at cycle 1, awready at cycle 4 -> wvalid drops after cycle 1, awvalid held to cycle 4, wstrb 4'b1100; no bready before cycle 5.
- Back-to-back: load, then data_req held for a store -> second addr_ok asserts exactly one cycle after the load's data_ok; never two outstanding transactions.
- rst pulsed while in RD_DATA with rvalid low -> next cycle all valids and readies 0, no data_ok; a new load is accepted normally afterwards.
- bresp = 2'b10 on a store -> data_ok still pulses once; state returns to IDLE.

Source files
------------

// File: rtl/data_sram_axi_bridge.sv
// Bridges the memory stage's data SRAM-like port onto a single-beat AXI4 master, one transaction in flight.
// Request accepted in IDLE; completion pulse in the cycle R or B is seen. Payload is held from latches until handshake.
module data_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_uncached,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        uncached_q;
  logic [3:0]  strb_q, strb_d;
  logic        aw_done, w_done;
  logic        accept;

  // Response status, IDs and rlast carry nothing this single-beat master acts on.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

  assign accept = (state == IDLE) && data_req && !rst;

  always_comb begin
    strb_d = 4'b0000;
    case (data_size)
      2'd0:    strb_d = 4'b0001 << data_addr[1:0];
      2'd1:    strb_d = 4'b0011 << data_addr[1:0];
      2'd2:    strb_d = 4'b1111;
      default: strb_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uncached_q <= 1'b0;
      strb_q     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q     <= data_addr;
        wdata_q    <= data_wdata;
        size_q     <= data_size;
        uncached_q <= data_uncached;
        strb_q     <= strb_d;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end else if (state == WR) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state)
      IDLE: begin
        data_addr_ok = accept;
        if (accept) state_nxt = data_wr ? WR : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok = 1'b1;
          data_rdata   = rdata;
          state_nxt    = IDLE;
        end
      end
      WR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        // Handshakes landing this cycle count as done, so simultaneous AW/W leave in one cycle.
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = uncached_q ? 4'b0000 : 4'b1111;
  assign arprot  = 3'b000;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = uncached_q ? 4'b0000 : 4'b1111;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed table-driven bench for data_sram_axi_bridge acting as the AXI slave and memory stage.
module tb_data_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr, data_uncached;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_sram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_uncached(data_uncached), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        unc;
    int          a_dly;   // cycles before arready / awready
    int          w_dly;   // cycles before wready
    int          r_dly;   // cycles before rvalid / bvalid
    logic [31:0] rdat;
    logic [1:0]  resp;
    logic [3:0]  strb;
    logic [3:0]  cache;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit aw_d, w_d;
    data_req = 1'b1; data_wr = v.wr; data_size = v.size; data_addr = v.addr;
    data_wdata = v.wdat; data_uncached = v.unc;
    @(negedge clk);
    chk($sformatf("v%0d_addr_ok", idx), 32'(data_addr_ok), 32'd1);
    chk($sformatf("v%0d_c0_valids", idx), 32'({arvalid, awvalid, wvalid}), 32'd0);
    step();
    // Scramble live inputs so any payload taken from them instead of the latches shows up.
    data_req = 1'b0; data_addr = ~v.addr; data_wdata = ~v.wdat; data_size = ~v.size;
    data_uncached = ~v.unc; data_wr = ~v.wr;
    if (!v.wr) begin
      for (int k = 0; k <= v.a_dly; k++) begin
        arready = (k == v.a_dly);
        @(negedge clk);
        chk($sformatf("v%0d_arvalid_k%0d", idx, k), 32'(arvalid), 32'd1);
        chk($sformatf("v%0d_araddr", idx), araddr, v.addr);
        chk($sformatf("v%0d_arsize", idx), 32'(arsize), 32'({1'b0, v.size}));
        chk($sformatf("v%0d_arcache", idx), 32'(arcache), 32'(v.cache));
        chk($sformatf("v%0d_ar_busy", idx), 32'({rready, data_data_ok, data_addr_ok}), 32'd0);
        step();
      end
      arready = 1'b0;
      for (int k = 0; k <= v.r_dly; k++) begin
        rvalid = (k == v.r_dly);
        rdata  = (k == v.r_dly) ? v.rdat : 32'h0BAD0BAD;
        @(negedge clk);
        chk($sformatf("v%0d_rready", idx), 32'({rready, arvalid}), 32'b10);
        chk($sformatf("v%0d_rd_data_ok_k%0d", idx, k), 32'(data_data_ok), 32'(k == v.r_dly));
        if (k == v.r_dly) chk($sformatf("v%0d_data_rdata", idx), data_rdata, v.rdat);
        step();
      end
      rvalid = 1'b0;
    end else begin
      aw_d = 1'b0; w_d = 1'b0;
      for (int k = 0; k < 20 && !(aw_d && w_d); k++) begin
        awready = (k >= v.a_dly);
        wready  = (k >= v.w_dly);
        @(negedge clk);
        chk($sformatf("v%0d_awvalid_k%0d", idx, k), 32'(awvalid), 32'(!aw_d));
        chk($sformatf("v%0d_wvalid_k%0d", idx, k), 32'(wvalid), 32'(!w_d));
        if (!aw_d) begin
          chk($sformatf("v%0d_awaddr", idx), awaddr, v.addr);
          chk($sformatf("v%0d_awsize", idx), 32'(awsize), 32'({1'b0, v.size}));
          chk($sformatf("v%0d_awcache", idx), 32'(awcache), 32'(v.cache));
        end
        if (!w_d) begin
          chk($sformatf("v%0d_wdata", idx), wdata, v.wdat);
          chk($sformatf("v%0d_wstrb", idx), 32'({wlast, wstrb}), 32'({1'b1, v.strb}));
        end
        chk($sformatf("v%0d_wr_busy_k%0d", idx, k), 32'({bready, data_data_ok}), 32'd0);
        @(posedge clk);
        if (k >= v.a_dly) aw_d = 1'b1;
        if (k >= v.w_dly) w_d = 1'b1;
        #1;
      end
      awready = 1'b0; wready = 1'b0;
      chk($sformatf("v%0d_wr_done", idx), 32'({aw_d, w_d}), 32'b11);
      for (int k = 0; k <= v.r_dly; k++) begin
        bvalid = (k == v.r_dly);
        bresp  = v.resp;
        @(negedge clk);
        chk($sformatf("v%0d_bready", idx), 32'({bready, awvalid, wvalid}), 32'b100);
        chk($sformatf("v%0d_wr_data_ok_k%0d", idx, k), 32'(data_data_ok), 32'(k == v.r_dly));
        if (k == v.r_dly) chk($sformatf("v%0d_wr_rdata", idx), data_rdata, 32'h0);
        step();
      end
      bvalid = 1'b0; bresp = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           wr size addr           wdat           unc a w r  rdat           resp  strb     cache
    vecs[0] = '{1'b0, 2'd2, 32'h00001004, 32'h0,        1'b0, 2, 0, 0, 32'hDEADBEEF, 2'b00, 4'b1111, 4'hF};
    vecs[1] = '{1'b1, 2'd0, 32'h1FC00003, 32'hABABABAB, 1'b1, 0, 0, 1, 32'h0,        2'b00, 4'b1000, 4'h0};
    vecs[2] = '{1'b1, 2'd1, 32'h00000102, 32'h55AA55AA, 1'b0, 3, 0, 0, 32'h0,        2'b00, 4'b1100, 4'hF};
    vecs[3] = '{1'b1, 2'd2, 32'h00002000, 32'h12345678, 1'b0, 0, 2, 0, 32'h0,        2'b00, 4'b1111, 4'hF};
    vecs[4] = '{1'b1, 2'd3, 32'h00000005, 32'h77777777, 1'b0, 1, 1, 0, 32'h0,        2'b00, 4'b0000, 4'hF};
    vecs[5] = '{1'b1, 2'd0, 32'h00000001, 32'h5A5A5A5A, 1'b0, 0, 0, 0, 32'h0,        2'b10, 4'b0010, 4'hF};
    vecs[6] = '{1'b0, 2'd0, 32'h1FC00002, 32'h0,        1'b1, 0, 0, 2, 32'h12345678, 2'b00, 4'b0000, 4'h0};
    vecs[7] = '{1'b0, 2'd1, 32'h00000006, 32'h0,        1'b0, 1, 0, 1, 32'hCAFE0001, 2'b00, 4'b0000, 4'hF};

    rst = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
    data_wdata = 32'h0; data_uncached = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = 4'd1; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b1;
    bid = 4'd1; bresp = 2'b00; bvalid = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("reset_outputs", 32'({arvalid, awvalid, wvalid, rready, bready, data_addr_ok, data_data_ok}), 32'd0);
    chk("reset_ids", 32'({arid, awid, wid}), 32'h111);
    chk("reset_latches", araddr | awaddr | wdata, 32'h0);
    step();
    rst = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("idle_ignores_r_b", 32'({rready, bready, data_data_ok}), 32'd0);
    step();
    rvalid = 1'b0; bvalid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Load followed immediately by a store held on data_req.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h00003000; data_uncached = 1'b0;
    @(negedge clk);
    chk("b2b_ld_addr_ok", 32'(data_addr_ok), 32'd1);
    step();
    data_wr = 1'b1; data_addr = 32'h00003004; data_wdata = 32'hCAFEF00D; arready = 1'b1;
    @(negedge clk);
    chk("b2b_busy_ar", 32'({data_addr_ok, arvalid}), 32'b01);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h11112222;
    @(negedge clk);
    chk("b2b_ld_done", 32'({data_data_ok, data_addr_ok, awvalid}), 32'b100);
    chk("b2b_ld_rdata", data_rdata, 32'h11112222);
    step();
    rvalid = 1'b0;
    @(negedge clk);
    chk("b2b_st_addr_ok", 32'({data_addr_ok, awvalid, data_data_ok}), 32'b100);
    step();
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    chk("b2b_st_aw_w", 32'({awvalid, wvalid, data_addr_ok}), 32'b110);
    chk("b2b_st_awaddr", awaddr, 32'h00003004);
    chk("b2b_st_wdata", wdata, 32'hCAFEF00D);
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    @(negedge clk);
    chk("b2b_st_done", 32'({data_data_ok, bready}), 32'b11);
    step();
    bvalid = 1'b0;

    // Reset while waiting in RD_DATA.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h00004000;
    @(negedge clk);
    chk("rst_ld_addr_ok", 32'(data_addr_ok), 32'd1);
    step();
    data_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    chk("rst_ld_arvalid", 32'(arvalid), 32'd1);
    step();
    arready = 1'b0;
    @(negedge clk);
    chk("rst_in_rd_data", 32'({rready, data_data_ok}), 32'b10);
    rst = 1'b1;
    step();
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("rst_after_outputs", 32'({arvalid, awvalid, wvalid, rready, bready, data_data_ok}), 32'd0);
    step();
    rvalid = 1'b0;
    run_vec(vecs[0], 8);

    @(negedge clk);
    chk("final_idle", 32'({data_data_ok, data_addr_ok, arvalid, awvalid, wvalid}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
